baud_tick_scheduler: RTL and testbench
======================================

Name: baud_tick_scheduler

Overview:
- Runtime-programmable baud tick controller for the UART.
- Owns the divisor register and the divide-by-M counter, and sequences start/stop and divisor changes so that tick periods never glitch.
- Produces the 16x oversampling tick (`s_tick`) for the receiver, and a phase-alignable bit tick (`tx_tick`) for the transmitter.
- Sits between the register/config interface and the UART rx/tx FSMs.

Parameters:
- DIV_W, 16, width of the divisor and of the divide counter.
- DIV_DEFAULT, 163, divisor loaded at reset (`s_tick` period in clk cycles).
- OVS, 16, oversampling ratio: number of `s_tick` per `tx_tick`; power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = generate ticks, 0 = stop and clear counters.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  DIV_W  requested divisor.
- cfg_ready  out  1  block can accept a divisor this cycle.
- cfg_err  out  1  one-cycle pulse: accepted divisor was <2 and was coerced to 2.
- tx_sync  in  1  one-cycle pulse: restart the tx bit phase (tx start of frame).
- s_tick  out  1  one-cycle oversample tick.
- tx_tick  out  1  one-cycle bit tick, coincident with an `s_tick`.
- div_active  out  DIV_W  divisor currently in use.
- running  out  1  high in RUN or PENDING.

Behaviour:
- Reset (synchronous, active-high, dominates all inputs):
  - state=IDLE, div_active=DIV_DEFAULT, div_cnt=0, ovs_cnt=0.
  - s_tick=0, tx_tick=0, cfg_err=0, cfg_ready=1, running=0.
  - A pending divisor is discarded.
- All outputs are registered.
- States:
  - IDLE: counters held at 0, no ticks.
    - enable=1 → RUN, div_cnt=0.
    - A handshake (cfg_valid&cfg_ready) in IDLE writes div_active on the next edge.
  - RUN: div_cnt counts 0..div_active-1.
    - When div_cnt==div_active-1: div_cnt←0 and s_tick=1 on the following cycle. Period is exactly div_active cycles.
    - First s_tick appears div_active cycles after the first RUN cycle.
    - Each s_tick increments ovs_cnt mod OVS. tx_tick=1 together with the s_tick that wraps ovs_cnt from OVS-1 to 0.
    - A handshake in RUN → PENDING; the divisor is latched into pend_div.
  - PENDING: counts exactly as RUN, with cfg_ready=0.
    - On the wrap edge (div_cnt==div_active-1): div_active←pend_div, state→RUN.
    - The in-flight period completes with the old divisor; the next period uses the new one.
  - enable=0 in RUN/PENDING → IDLE on the next edge.
    - Counters are cleared; no further ticks.
    - A pending divisor is applied immediately (div_active←pend_div).
- cfg_ready:
  - 1 in IDLE and RUN; 0 in PENDING.
  - In the cycle enable falls, cfg_ready follows the current state.
- Coercion: an accepted cfg_div of 0 or 1 is stored as 2; cfg_err pulses 1 the cycle after acceptance. All other values are stored unchanged.
- tx_sync (ignored in IDLE):
  - Next edge: div_cnt←0, ovs_cnt←0. No tick is emitted for the truncated period.
  - The next tx_tick is exactly OVS×div_active cycles after the cleared cycle.
- tx_sync coincident with a div_cnt wrap: tx_sync wins. No s_tick; the pending divisor is still applied.
- Handshake and enable fall in the same cycle: the divisor is accepted and written to div_active on entry to IDLE.
- div_active updates only at a wrap, in IDLE, or on entry to IDLE; never mid-period.

Optional Feature:
- Macro BAUD_SCHED_STATS_EN.
- When defined:
  - Adds output `tx_tick_cnt` [15:0]: a wrapping count of emitted tx_ticks.
  - Reset to 0; cleared on IDLE entry; increments by 1 on each tx_tick; wraps 0xFFFF→0x0000.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Default config:
  - reset 1 cycle, then enable=1 → first s_tick 163 cycles after RUN entry.
  - s_tick period 163; tx_tick every 2608 cycles, coincident with every 16th s_tick; div_active=163.
- Mid-run reconfig: cfg_div=10 accepted at div_cnt=50 →
  - cfg_ready=0 until the wrap.
  - The current period still ends at 163 cycles; subsequent s_tick period is 10; div_active=10 after the wrap.
- Coercion: cfg_div=0 accepted in IDLE → div_active=2, cfg_err 1-cycle pulse; after enable, s_tick every 2 cycles.
- tx_sync pulse at ovs_cnt=7, div=20 →
  - no tick in the truncated period;
  - next s_tick 20 cycles later; next tx_tick 320 cycles after the clear.
- Stop/restart: enable=0 at div_cnt=80 → no ticks, running=0 next cycle; re-enable → first s_tick after a full 163 cycles.
- Reset mid-PENDING (pend_div=10, div=163): reset → div_active=163, cfg_ready=1, no ticks; with BAUD_SCHED_STATS_EN, tx_tick_cnt=0.

Source files
------------

// File: rtl/baud_tick_scheduler.sv
// Baud tick scheduler: divisor register, divide-by-M counter, s_tick/tx_tick sequencing.
// Optional macro BAUD_SCHED_STATS_EN adds the tx_tick_cnt output.
module baud_tick_scheduler #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 163,
    parameter int OVS         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             tx_sync,
    output logic             s_tick,
    output logic             tx_tick,
    output logic [DIV_W-1:0] div_active,
    output logic             running
`ifdef BAUD_SCHED_STATS_EN
    ,
    output logic [15:0]      tx_tick_cnt
`endif
);

    localparam int OVS_W = $clog2(OVS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] div_cnt, div_cnt_nx;
    logic [DIV_W-1:0] div_nx;
    logic [DIV_W-1:0] pend_div, pend_div_nx;
    logic [OVS_W-1:0] ovs_cnt, ovs_cnt_nx;
    logic             s_tick_nx, tx_tick_nx, cfg_err_nx;
    logic             hs, wrap;
    logic [DIV_W-1:0] div_req;

    assign hs      = cfg_valid & cfg_ready;
    assign div_req = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign wrap    = (div_cnt == div_active - DIV_W'(1));

    always_comb begin
        state_nx    = state;
        div_cnt_nx  = div_cnt;
        ovs_cnt_nx  = ovs_cnt;
        div_nx      = div_active;
        pend_div_nx = pend_div;
        s_tick_nx   = 1'b0;
        tx_tick_nx  = 1'b0;
        cfg_err_nx  = hs & (cfg_div < DIV_W'(2));
        case (state)
            IDLE: begin
                div_cnt_nx = '0;
                ovs_cnt_nx = '0;
                if (hs) div_nx = div_req;
                if (enable) state_nx = RUN;
            end
            default: begin
                if (!enable) begin
                    // leaving RUN/PEND: whatever divisor is queued takes effect now
                    state_nx   = IDLE;
                    div_cnt_nx = '0;
                    ovs_cnt_nx = '0;
                    if (state == PEND) div_nx = pend_div;
                    else if (hs) div_nx = div_req;
                end else begin
                    if (hs) begin
                        pend_div_nx = div_req;
                        state_nx    = PEND;
                    end
                    if (tx_sync) begin
                        div_cnt_nx = '0;
                        ovs_cnt_nx = '0;
                    end else if (wrap) begin
                        div_cnt_nx = '0;
                        s_tick_nx  = 1'b1;
                        ovs_cnt_nx = ovs_cnt + OVS_W'(1);
                        tx_tick_nx = (ovs_cnt == OVS_W'(OVS - 1));
                    end else begin
                        div_cnt_nx = div_cnt + DIV_W'(1);
                    end
                    if (state == PEND && wrap) begin
                        div_nx   = pend_div;
                        state_nx = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            ovs_cnt    <= '0;
            div_active <= DIV_W'(DIV_DEFAULT);
            pend_div   <= DIV_W'(DIV_DEFAULT);
            s_tick     <= 1'b0;
            tx_tick    <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_ready  <= 1'b1;
            running    <= 1'b0;
        end else begin
            state      <= state_nx;
            div_cnt    <= div_cnt_nx;
            ovs_cnt    <= ovs_cnt_nx;
            div_active <= div_nx;
            pend_div   <= pend_div_nx;
            s_tick     <= s_tick_nx;
            tx_tick    <= tx_tick_nx;
            cfg_err    <= cfg_err_nx;
            cfg_ready  <= (state_nx != PEND);
            running    <= (state_nx != IDLE);
        end
    end

`ifdef BAUD_SCHED_STATS_EN
    logic [15:0] tx_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt_q <= '0;
        end else if (state != IDLE && state_nx == IDLE) begin
            tx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_q + {15'd0, tx_tick};
        end
    end

    assign tx_tick_cnt = tx_cnt_q;
`endif

endmodule

// File: tb/tb_baud_tick_scheduler.sv
// Bench for baud_tick_scheduler: directed scenarios plus randomized traffic
// against a time-based reference model (absolute tick deadlines).
module tb_baud_tick_scheduler;

    localparam int DIV_W = 16;
    localparam int DEF   = 163;
    localparam int OVS   = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             tx_sync = 1'b0;
    logic             cfg_ready, cfg_err, s_tick, tx_tick, running;
    logic [DIV_W-1:0] div_active;
`ifdef BAUD_SCHED_STATS_EN
    logic [15:0]      tx_tick_cnt;
`endif

    int vecs  = 0;
    int fails = 0;

    baud_tick_scheduler #(
        .DIV_W      (DIV_W),
        .DIV_DEFAULT(DEF),
        .OVS        (OVS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tx_sync   (tx_sync),
        .s_tick    (s_tick),
        .tx_tick   (tx_tick),
        .div_active(div_active),
        .running   (running)
`ifdef BAUD_SCHED_STATS_EN
        ,
        .tx_tick_cnt(tx_tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: tracks the absolute cycle of the next s_tick.
    int unsigned cyc = 0;
    bit          m_run = 0, m_pv = 0;
    int          m_div = DEF, m_pend = DEF, m_nt = 0;
    int unsigned m_next = 0;
    bit          e_s = 0, e_tx = 0, e_err = 0;
    logic [15:0] e_cnt = '0;

    function automatic int coerce(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    always @(posedge clk) begin
        bit hs, wrap, prev_tx;
        hs      = cfg_valid && !m_pv;
        prev_tx = e_tx;
        e_s     = 0;
        e_tx    = 0;
        e_err   = 0;
        if (reset) begin
            m_run = 0;
            m_pv  = 0;
            m_div = DEF;
            e_cnt = '0;
        end else begin
            e_err = hs && (cfg_div < 2);
            if (!m_run) begin
                if (hs) m_div = coerce(int'(cfg_div));
                if (enable) begin
                    m_run  = 1;
                    m_nt   = 0;
                    m_next = cyc + 1 + m_div;
                end
                e_cnt = e_cnt + {15'd0, prev_tx};
            end else if (!enable) begin
                m_run = 0;
                if (m_pv) m_div = m_pend;
                else if (hs) m_div = coerce(int'(cfg_div));
                m_pv  = 0;
                e_cnt = '0;
            end else begin
                wrap = (cyc + 1 == m_next);
                if (wrap && m_pv) begin
                    m_div = m_pend;
                    m_pv  = 0;
                end
                if (hs) begin
                    m_pend = coerce(int'(cfg_div));
                    m_pv   = 1;
                end
                if (tx_sync) begin
                    m_nt   = 0;
                    m_next = cyc + 1 + m_div;
                end else if (wrap) begin
                    e_s    = 1;
                    m_nt   = m_nt + 1;
                    e_tx   = (m_nt % OVS) == 0;
                    m_next = cyc + 1 + m_div;
                end
                e_cnt = e_cnt + {15'd0, prev_tx};
            end
        end
        cyc = cyc + 1;
    end

`ifdef BAUD_SCHED_STATS_EN
    wire [DIV_W+20:0] dut_v = {s_tick, tx_tick, cfg_ready, cfg_err, running, div_active, tx_tick_cnt};
    wire [DIV_W+20:0] exp_v = {e_s, e_tx, !m_pv, e_err, m_run, DIV_W'(m_div), e_cnt};
`else
    wire [DIV_W+4:0] dut_v = {s_tick, tx_tick, cfg_ready, cfg_err, running, div_active};
    wire [DIV_W+4:0] exp_v = {e_s, e_tx, !m_pv, e_err, m_run, DIV_W'(m_div)};
`endif

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        cfg_valid = 1'b0;
        tx_sync = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs += 6;
        if (s_tick !== 1'b0) begin fails++; $display("FAIL reset_s_tick got %b exp 0", s_tick); end
        if (tx_tick !== 1'b0) begin fails++; $display("FAIL reset_tx_tick got %b exp 0", tx_tick); end
        if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
        if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
        if (running !== 1'b0) begin fails++; $display("FAIL reset_running got %b exp 0", running); end
        if (div_active !== DIV_W'(DEF)) begin fails++; $display("FAIL reset_div got %0d exp %0d", div_active, DEF); end
        reset = 1'b0;
    endtask

    task automatic test_default();
        int first_s = -1, first_tx = -1, n_s = 0;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 2 * DEF * OVS + 10; k++) begin
            @(posedge clk);
            #1;
            vecs++;
            if (dut_v !== exp_v) begin fails++; $display("FAIL default k=%0d got %h exp %h", k, dut_v, exp_v); end
            if (s_tick) n_s++;
            if (s_tick && first_s < 0) first_s = k;
            if (tx_tick && first_tx < 0) first_tx = k;
            if (tx_tick && (n_s % OVS) != 0) begin fails++; $display("FAIL default_tx_align n_s=%0d exp multiple of %0d", n_s, OVS); end
        end
        vecs += 2;
        if (first_s != DEF + 1) begin fails++; $display("FAIL first_s_tick got %0d exp %0d", first_s, DEF + 1); end
        if (first_tx != DEF * OVS + 1) begin fails++; $display("FAIL first_tx_tick got %0d exp %0d", first_tx, DEF * OVS + 1); end
    endtask

    task automatic test_reconfig();
        int ticks[$];
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            vecs++;
            if (dut_v !== exp_v) begin fails++; $display("FAIL reconfig k=%0d got %h exp %h", k, dut_v, exp_v); end
            if (s_tick) ticks.push_back(k);
            if (k == 52) begin
                vecs++;
                if (cfg_ready !== 1'b0) begin fails++; $display("FAIL reconfig_ready got %b exp 0", cfg_ready); end
            end
            if (k == DEF + 1) begin
                vecs++;
                if (div_active !== DIV_W'(10)) begin fails++; $display("FAIL reconfig_div got %0d exp 10", div_active); end
            end
            cfg_valid = (k == 51);
            cfg_div   = 16'd10;
        end
        vecs++;
        if (ticks.size() < 3 || ticks[0] != DEF + 1 || ticks[1] - ticks[0] != 10 || ticks[2] - ticks[1] != 10) begin
            fails++;
            $display("FAIL reconfig_periods got n=%0d first=%0d exp first=%0d then period 10", ticks.size(), (ticks.size() > 0) ? ticks[0] : -1, DEF + 1);
        end
    endtask

    task automatic test_coerce();
        int n_s = 0;
        do_reset();
        cfg_valid = 1'b1;
        cfg_div   = 16'd0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        vecs += 2;
        if (cfg_err !== 1'b1) begin fails++; $display("FAIL coerce_err got %b exp 1", cfg_err); end
        if (div_active !== DIV_W'(2)) begin fails++; $display("FAIL coerce_div got %0d exp 2", div_active); end
        enable = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            vecs++;
            if (dut_v !== exp_v) begin fails++; $display("FAIL coerce k=%0d got %h exp %h", k, dut_v, exp_v); end
            if (s_tick) n_s++;
        end
        vecs++;
        if (n_s != 29) begin fails++; $display("FAIL coerce_ticks got %0d exp 29", n_s); end
    endtask

    task automatic test_tx_sync();
        int n_s = 0, since = 0, sync_k = -1, d_s = -1, d_tx = -1;
        do_reset();
        cfg_valid = 1'b1;
        cfg_div   = 16'd20;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            vecs++;
            if (dut_v !== exp_v) begin fails++; $display("FAIL tx_sync k=%0d got %h exp %h", k, dut_v, exp_v); end
            since++;
            if (s_tick) begin n_s++; since = 0; end
            if (sync_k >= 0 && k >= sync_k) begin
                if (s_tick && d_s < 0) d_s = k - sync_k;
                if (tx_tick && d_tx < 0) d_tx = k - sync_k;
            end
            tx_sync = (sync_k < 0 && n_s == 7 && since == 10);
            if (tx_sync) sync_k = k + 1;
        end
        vecs += 2;
        if (d_s != 20) begin fails++; $display("FAIL tx_sync_s_delay got %0d exp 20", d_s); end
        if (d_tx != 320) begin fails++; $display("FAIL tx_sync_tx_delay got %0d exp 320", d_tx); end
    endtask

    task automatic test_stop_restart();
        int re_k = -1, first = -1;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            vecs++;
            if (dut_v !== exp_v) begin fails++; $display("FAIL stop k=%0d got %h exp %h", k, dut_v, exp_v); end
            if (k == 82) begin
                vecs++;
                if (running !== 1'b0) begin fails++; $display("FAIL stop_running got %b exp 0", running); end
            end
            if (re_k >= 0 && s_tick && first < 0) first = k - re_k;
            if (k == 81) enable = 1'b0;
            if (k == 110) begin enable = 1'b1; re_k = k + 1; end
        end
        vecs++;
        if (first != DEF) begin fails++; $display("FAIL restart_first got %0d exp %0d", first, DEF); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            vecs++;
            if (dut_v !== exp_v) begin fails++; $display("FAIL rst_pend k=%0d got %h exp %h", k, dut_v, exp_v); end
            if (k == 61) begin
                vecs += 3;
                if (div_active !== DIV_W'(DEF)) begin fails++; $display("FAIL rst_pend_div got %0d exp %0d", div_active, DEF); end
                if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_pend_ready got %b exp 1", cfg_ready); end
                if (s_tick !== 1'b0) begin fails++; $display("FAIL rst_pend_tick got %b exp 0", s_tick); end
`ifdef BAUD_SCHED_STATS_EN
                vecs++;
                if (tx_tick_cnt !== 16'd0) begin fails++; $display("FAIL rst_pend_cnt got %0d exp 0", tx_tick_cnt); end
`endif
            end
            cfg_valid = (k == 51);
            cfg_div   = 16'd10;
            reset     = (k == 60);
            if (k == 60) enable = 1'b0;
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 1; k <= 20000; k++) begin
            @(posedge clk);
            #1;
            vecs++;
            if (dut_v !== exp_v) begin fails++; $display("FAIL random k=%0d got %h exp %h", k, dut_v, exp_v); end
            cfg_valid = ($urandom_range(0, 19) == 0);
            cfg_div   = DIV_W'($urandom_range(0, 9));
            tx_sync   = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 2999) == 0);
            if (enable) enable = ($urandom_range(0, 299) != 0);
            else enable = ($urandom_range(0, 4) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_reconfig();
        test_coerce();
        test_tx_sync();
        test_stop_restart();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
